// File: rtl/up_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : up_down_counter
// Description : Synchronous up/down counter with a single direction select.
//               Steps once per rising clock edge, either wrapping around
//               or saturating at the ends of the range 0..MODULUS-1.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        counter width in bits (>= 1)
//   MODULUS      count range is 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE     0: wrap at range ends, 1: hold at range ends
//   RESET_VALUE  value loaded by reset, must be < MODULUS
// Ports
//   q    out  WIDTH  current count, straight from the state register
//   rst  in   1      synchronous reset, active-low
//   s    in   1      direction: 1 = up, 0 = down
//   clc  in   1      clock, rising edge
// ============================================================================
module up_down_counter #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 2**WIDTH,
    parameter bit SATURATE    = 1'b0,
    parameter int RESET_VALUE = 0
) (
    output logic [WIDTH-1:0] q,
    input  logic             rst,
    input  logic             s,
    input  logic             clc
);

    // Top of the count range. Compared explicitly so that a modulus that
    // is not a power of two behaves exactly like a power-of-two one.
    localparam logic [WIDTH-1:0] c_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_RST   = WIDTH'(RESET_VALUE);

    // Value taken when stepping past either end of the range: the far end
    // when wrapping, the same end when saturating.
    localparam logic [WIDTH-1:0] c_UP_END = SATURATE ? c_MAX : '0;
    localparam logic [WIDTH-1:0] c_DN_END = SATURATE ? '0    : c_MAX;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (s) begin
            // ">=" rather than "==" keeps the next value in range even if
            // the register ever held something above the top of the range.
            if (count_q >= c_MAX) begin
                count_d = c_UP_END;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else begin
            if (count_q == '0) begin
                count_d = c_DN_END;
            end else if (count_q > c_MAX) begin
                count_d = c_MAX;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Reset wins over counting; no enable, so every edge updates the count.
    always_ff @(posedge clc) begin
        if (!rst) begin
            count_q <= c_RST;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule
`default_nettype wire

// File: tb/tb_up_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_up_down_counter
// Description : Scoreboard bench for up_down_counter. Drives a default
//               wrapping instance and a MODULUS=10 saturating instance with
//               the same reset/direction stimulus and checks both against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_down_counter;

    localparam int c_MOD_A = 16;
    localparam int c_MOD_B = 10;

    logic       clc = 1'b0;
    logic       rst = 1'b1;
    logic       s   = 1'b0;
    logic [3:0] q_a;
    logic [3:0] q_b;

    always #5 clc = ~clc;

    up_down_counter #(.WIDTH(4)) u_wrap (
        .q   (q_a),
        .rst (rst),
        .s   (s),
        .clc (clc)
    );

    up_down_counter #(.WIDTH(4), .MODULUS(c_MOD_B), .SATURATE(1'b1), .RESET_VALUE(0)) u_sat (
        .q   (q_b),
        .rst (rst),
        .s   (s),
        .clc (clc)
    );

    typedef struct {
        int exp_a;
        int exp_b;
        int step;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_steps  = 0;
    int model_a  = 0;
    int model_b  = 0;

    // Reference: next count from the arithmetic rules of the range.
    function automatic int ref_next(input int cur, input bit r, input bit up,
                                    input int m, input bit sat);
        if (!r)  return 0;
        if (sat) begin
            if (up) return (cur + 1 > m - 1) ? m - 1 : cur + 1;
            else    return (cur - 1 < 0) ? 0 : cur - 1;
        end
        if (up) return (cur + 1) % m;
        return (cur - 1 + m) % m;
    endfunction

    // Issue one clock worth of stimulus and queue the expected result.
    task automatic step(input bit r, input bit up);
        exp_t e;
        @(negedge clc);
        rst = r;
        s   = up;
        model_a = ref_next(model_a, r, up, c_MOD_A, 1'b0);
        model_b = ref_next(model_b, r, up, c_MOD_B, 1'b1);
        e.exp_a = model_a;
        e.exp_b = model_b;
        e.step  = n_steps;
        n_steps++;
        sb.push_back(e);
    endtask

    // Monitor: the counter presents a new value after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clc);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ($isunknown(q_a) || int'(q_a) != e.exp_a) begin
                    n_fail++;
                    $display("FAIL wrap_q step %0d: got %0d expected %0d", e.step, q_a, e.exp_a);
                end
                n_checks++;
                if ($isunknown(q_b) || int'(q_b) != e.exp_b) begin
                    n_fail++;
                    $display("FAIL sat_q step %0d: got %0d expected %0d", e.step, q_b, e.exp_b);
                end
                n_checks++;
                if ($isunknown(q_b) || int'(q_b) >= c_MOD_B) begin
                    n_fail++;
                    $display("FAIL sat_range step %0d: got %0d required below %0d", e.step, q_b, c_MOD_B);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Held in reset for 10 edges with arbitrary direction.
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom));

        // 2. Count up 20 edges: wrap instance passes 15 -> 0, saturating
        //    instance stops at 9.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

        // 3. Back to 0 then down: 15,14,13 / saturating stays at 0 after
        //    its own descent.
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        // 4. Reach 7, flip down then back up.
        step(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // 5. Reset in the middle of counting at 9, then resume.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // 6. Saturation: 12 up, then 12 down.
        step(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);

        // Alternating direction every cycle.
        for (int i = 0; i < 16; i++) step(1'b1, 1'(i % 2));

        // Random direction with occasional reset.
        for (int i = 0; i < 400; i++) step(($urandom_range(0, 19) != 0), 1'($urandom));

        @(posedge clc);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
